// File: rtl/coolgirl_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// coolgirl_cfg_ctrl
//
// Turns CPU writes into the $5000-$5FFF multicart configuration window into
// the control fields of the mapping datapath. Register writes R0-R6 only land
// in shadow copies. A commit (R7, D0=1) copies every shadow field into the
// active outputs on one edge, so the datapath never sees a half-written setup.
// An optional lock freezes the configuration until reset. A power-on hold
// window ignores bus activity while the console comes up.
//
// All state changes on the falling edge of m2.
//
// Ports:
//   m2                 CPU M2, the only clock (falling edge active)
//   reset_n            asynchronous active-low reset
//   romsel             CPU /ROMSEL
//   cpu_rw_in          CPU R/W (0 = write)
//   cpu_addr_in[14:0]  CPU A14..A0
//   cpu_data_in[7:0]   CPU data bus
//   cpu_base[12:0]     active PRG base, address bits [26:14]
//   prg_mask[6:0]      active PRG mask, address bits [20:14]
//   chr_mask[4:0]      active CHR mask, address bits [17:13]
//   sram_page[1:0]     active SRAM page
//   sram_enabled       SRAM enable
//   prg_write_enabled  flash write enable
//   chr_write_enabled  CHR write enable
//   map_rom_on_6000    ROM mapped at $6000
//   four_screen        four-screen enable
//   mapper[4:0]        active mapper select
//   cfg_locked         high while the configuration is locked
//   cfg_changed        one-cycle pulse on the edge the active fields load
//   state_o[1:0]       FSM state (0 INIT, 1 OPEN, 2 COMMIT, 3 LOCKED)
//
// Bus handshake: there is no valid/ready pair. A write is a single bus cycle
// qualified by romsel=1, cpu_rw_in=0 and A14..A12=101; it is accepted or
// dropped on that cycle's falling m2 edge and never stalls the CPU.
// ---------------------------------------------------------------------------
module coolgirl_cfg_ctrl #(
    parameter int unsigned INIT_CYCLES    = 15,
    parameter logic [6:0]  RESET_PRG_MASK = 7'h7E,
    parameter bit          ENABLE_LOCK    = 1'b1
) (
    input  logic        m2,
    input  logic        reset_n,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    output logic [12:0] cpu_base,
    output logic [6:0]  prg_mask,
    output logic [4:0]  chr_mask,
    output logic [1:0]  sram_page,
    output logic        sram_enabled,
    output logic        prg_write_enabled,
    output logic        chr_write_enabled,
    output logic        map_rom_on_6000,
    output logic        four_screen,
    output logic [4:0]  mapper,
    output logic        cfg_locked,
    output logic        cfg_changed,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_OPEN   = 2'd1,
        S_COMMIT = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES);

    state_t      state_q;
    logic [3:0]  init_cnt_q;
    logic        pending_lock_q;

    // Shadow copies, written by R0-R6
    logic [12:0] sh_base_q;
    logic [6:0]  sh_prg_mask_q;
    logic [4:0]  sh_chr_mask_q;
    logic [1:0]  sh_sram_page_q;
    logic        sh_sram_en_q;
    logic        sh_prg_we_q;
    logic        sh_chr_we_q;
    logic        sh_rom6000_q;
    logic        sh_four_q;
    logic [4:0]  sh_mapper_q;

    // Active copies, loaded only in COMMIT
    logic [12:0] act_base_q;
    logic [6:0]  act_prg_mask_q;
    logic [4:0]  act_chr_mask_q;
    logic [1:0]  act_sram_page_q;
    logic        act_sram_en_q;
    logic        act_prg_we_q;
    logic        act_chr_we_q;
    logic        act_rom6000_q;
    logic        act_four_q;
    logic [4:0]  act_mapper_q;
    logic        cfg_locked_q;
    logic        cfg_changed_q;

    logic        wr;
    logic [2:0]  reg_idx;
    logic        shadow_open;
    logic        unused_addr;

    // A11..A3 are mirrored and deliberately ignored
    assign unused_addr = ^cpu_addr_in[11:3];

    assign wr          = romsel & ~cpu_rw_in & (cpu_addr_in[14:12] == 3'b101);
    assign reg_idx     = cpu_addr_in[2:0];
    // Shadow stays writable during the COMMIT cycle; the active copy loads the
    // pre-write shadow because both use the register values from before the edge.
    assign shadow_open = (state_q == S_OPEN) || (state_q == S_COMMIT);

    always_ff @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_INIT;
            init_cnt_q      <= INIT_LOAD;
            pending_lock_q  <= 1'b0;
            sh_base_q       <= '0;
            sh_prg_mask_q   <= RESET_PRG_MASK;
            sh_chr_mask_q   <= '0;
            sh_sram_page_q  <= '0;
            sh_sram_en_q    <= 1'b0;
            sh_prg_we_q     <= 1'b0;
            sh_chr_we_q     <= 1'b0;
            sh_rom6000_q    <= 1'b0;
            sh_four_q       <= 1'b0;
            sh_mapper_q     <= '0;
            act_base_q      <= '0;
            act_prg_mask_q  <= RESET_PRG_MASK;
            act_chr_mask_q  <= '0;
            act_sram_page_q <= '0;
            act_sram_en_q   <= 1'b0;
            act_prg_we_q    <= 1'b0;
            act_chr_we_q    <= 1'b0;
            act_rom6000_q   <= 1'b0;
            act_four_q      <= 1'b0;
            act_mapper_q    <= '0;
            cfg_locked_q    <= 1'b0;
            cfg_changed_q   <= 1'b0;
        end else begin
            cfg_changed_q <= 1'b0;

            if (wr && shadow_open) begin
                case (reg_idx)
                    3'd0: sh_base_q[12:8] <= cpu_data_in[4:0];
                    3'd1: sh_base_q[7:0]  <= cpu_data_in;
                    3'd2: sh_prg_mask_q   <= cpu_data_in[6:0];
                    3'd3: sh_chr_mask_q   <= cpu_data_in[4:0];
                    3'd4: begin
                        sh_sram_page_q <= cpu_data_in[1:0];
                        sh_sram_en_q   <= cpu_data_in[7];
                    end
                    3'd5: sh_mapper_q     <= cpu_data_in[4:0];
                    3'd6: begin
                        sh_prg_we_q  <= cpu_data_in[0];
                        sh_chr_we_q  <= cpu_data_in[1];
                        sh_rom6000_q <= cpu_data_in[2];
                        sh_four_q    <= cpu_data_in[3];
                    end
                    default: ;
                endcase
            end

            case (state_q)
                S_INIT: begin
                    if (init_cnt_q != 4'd0) begin
                        init_cnt_q <= init_cnt_q - 4'd1;
                    end
                    // Leaving on the edge the count reaches zero makes the
                    // next edge the first one that accepts a write.
                    if (init_cnt_q <= 4'd1) begin
                        state_q <= S_OPEN;
                    end
                end
                S_OPEN: begin
                    if (wr && (reg_idx == 3'd7) && cpu_data_in[0]) begin
                        state_q        <= S_COMMIT;
                        pending_lock_q <= cpu_data_in[7] & ENABLE_LOCK;
                    end
                end
                S_COMMIT: begin
                    act_base_q      <= sh_base_q;
                    act_prg_mask_q  <= sh_prg_mask_q;
                    act_chr_mask_q  <= sh_chr_mask_q;
                    act_sram_page_q <= sh_sram_page_q;
                    act_sram_en_q   <= sh_sram_en_q;
                    act_prg_we_q    <= sh_prg_we_q;
                    act_chr_we_q    <= sh_chr_we_q;
                    act_rom6000_q   <= sh_rom6000_q;
                    act_four_q      <= sh_four_q;
                    act_mapper_q    <= sh_mapper_q;
                    cfg_changed_q   <= 1'b1;
                    pending_lock_q  <= 1'b0;
                    if (pending_lock_q) begin
                        state_q      <= S_LOCKED;
                        cfg_locked_q <= 1'b1;
                    end else begin
                        state_q <= S_OPEN;
                    end
                end
                S_LOCKED: ;
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign cpu_base          = act_base_q;
    assign prg_mask          = act_prg_mask_q;
    assign chr_mask          = act_chr_mask_q;
    assign sram_page         = act_sram_page_q;
    assign sram_enabled      = act_sram_en_q;
    assign prg_write_enabled = act_prg_we_q;
    assign chr_write_enabled = act_chr_we_q;
    assign map_rom_on_6000   = act_rom6000_q;
    assign four_screen       = act_four_q;
    assign mapper            = act_mapper_q;
    assign cfg_locked        = cfg_locked_q;
    assign cfg_changed       = cfg_changed_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_coolgirl_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for coolgirl_cfg_ctrl. Two instances share one CPU bus:
//   inst 0: defaults (INIT_CYCLES 15, reset mask 7'h7E, lock enabled)
//   inst 1: INIT_CYCLES 4, reset mask 7'h3C, lock disabled
// A reference model holds, per instance, the shadow and active configuration
// as plain records and applies the register rules once per falling m2 edge.
// ---------------------------------------------------------------------------
module tb_coolgirl_cfg_ctrl;

    typedef struct packed {
        logic [12:0] base;
        logic [6:0]  pmask;
        logic [4:0]  cmask;
        logic [1:0]  spage;
        logic        sen;
        logic        pwe;
        logic        cwe;
        logic        rom6;
        logic        fs;
        logic [4:0]  mapper;
    } cfg_t;

    logic        m2;
    logic        reset_n;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;

    logic [12:0] cpu_base [2];
    logic [6:0]  prg_mask [2];
    logic [4:0]  chr_mask [2];
    logic [1:0]  sram_page [2];
    logic        sram_enabled [2];
    logic        prg_write_enabled [2];
    logic        chr_write_enabled [2];
    logic        map_rom_on_6000 [2];
    logic        four_screen [2];
    logic [4:0]  mapper [2];
    logic        cfg_locked [2];
    logic        cfg_changed [2];
    logic [1:0]  state_dbg [2];
    cfg_t        got [2];

    int n_run;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial begin
        m2 = 1'b1;
        forever #5 m2 = ~m2;
    end

    coolgirl_cfg_ctrl u_dut0 (
        .m2(m2), .reset_n(reset_n), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
        .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .cpu_base(cpu_base[0]), .prg_mask(prg_mask[0]), .chr_mask(chr_mask[0]),
        .sram_page(sram_page[0]), .sram_enabled(sram_enabled[0]),
        .prg_write_enabled(prg_write_enabled[0]), .chr_write_enabled(chr_write_enabled[0]),
        .map_rom_on_6000(map_rom_on_6000[0]), .four_screen(four_screen[0]),
        .mapper(mapper[0]), .cfg_locked(cfg_locked[0]), .cfg_changed(cfg_changed[0]),
        .state_o(state_dbg[0])
    );

    coolgirl_cfg_ctrl #(
        .INIT_CYCLES(4), .RESET_PRG_MASK(7'h3C), .ENABLE_LOCK(1'b0)
    ) u_dut1 (
        .m2(m2), .reset_n(reset_n), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
        .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .cpu_base(cpu_base[1]), .prg_mask(prg_mask[1]), .chr_mask(chr_mask[1]),
        .sram_page(sram_page[1]), .sram_enabled(sram_enabled[1]),
        .prg_write_enabled(prg_write_enabled[1]), .chr_write_enabled(chr_write_enabled[1]),
        .map_rom_on_6000(map_rom_on_6000[1]), .four_screen(four_screen[1]),
        .mapper(mapper[1]), .cfg_locked(cfg_locked[1]), .cfg_changed(cfg_changed[1]),
        .state_o(state_dbg[1])
    );

    assign got[0] = {cpu_base[0], prg_mask[0], chr_mask[0], sram_page[0], sram_enabled[0],
                     prg_write_enabled[0], chr_write_enabled[0], map_rom_on_6000[0],
                     four_screen[0], mapper[0]};
    assign got[1] = {cpu_base[1], prg_mask[1], chr_mask[1], sram_page[1], sram_enabled[1],
                     prg_write_enabled[1], chr_write_enabled[1], map_rom_on_6000[1],
                     four_screen[1], mapper[1]};

    // ---------------- reference model ----------------
    cfg_t m_sh [2];
    cfg_t m_act [2];
    bit   m_chg [2];
    bit   m_lck [2];
    bit   m_pend [2];
    bit   m_lreq [2];
    int   m_edges [2];
    bit       mdl_wr;
    int       mdl_idx;
    logic [7:0] mdl_d;
    bit       mdl_was;

    function automatic int init_of(input int i);
        return (i == 0) ? 15 : 4;
    endfunction

    function automatic bit lock_en_of(input int i);
        return (i == 0);
    endfunction

    function automatic cfg_t reset_cfg(input int i);
        cfg_t c;
        c = '0;
        c.pmask = (i == 0) ? 7'h7E : 7'h3C;
        return c;
    endfunction

    always @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_sh[i] = reset_cfg(i);
                m_act[i] = reset_cfg(i);
                m_chg[i] = 0; m_lck[i] = 0; m_pend[i] = 0; m_lreq[i] = 0; m_edges[i] = 0;
            end
        end else begin
            mdl_wr  = romsel && !cpu_rw_in && (cpu_addr_in[14:12] == 3'b101);
            mdl_idx = int'(cpu_addr_in[2:0]);
            mdl_d   = cpu_data_in;
            for (int i = 0; i < 2; i++) begin
                m_chg[i] = 0;
                if (!m_lck[i]) begin
                    m_edges[i]++;
                    mdl_was = m_pend[i];
                    if (mdl_was) begin
                        m_act[i]  = m_sh[i];
                        m_chg[i]  = 1;
                        m_lck[i]  = m_lreq[i];
                        m_pend[i] = 0;
                    end
                    if (mdl_wr && m_edges[i] > init_of(i)) begin
                        case (mdl_idx)
                            0: m_sh[i].base[12:8] = mdl_d[4:0];
                            1: m_sh[i].base[7:0]  = mdl_d;
                            2: m_sh[i].pmask      = mdl_d[6:0];
                            3: m_sh[i].cmask      = mdl_d[4:0];
                            4: begin m_sh[i].spage = mdl_d[1:0]; m_sh[i].sen = mdl_d[7]; end
                            5: m_sh[i].mapper     = mdl_d[4:0];
                            6: begin
                                m_sh[i].pwe = mdl_d[0]; m_sh[i].cwe = mdl_d[1];
                                m_sh[i].rom6 = mdl_d[2]; m_sh[i].fs = mdl_d[3];
                            end
                            default: begin
                                if (!mdl_was && mdl_d[0]) begin
                                    m_pend[i] = 1;
                                    m_lreq[i] = mdl_d[7] && lock_en_of(i);
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge m2);
        romsel = 1'b0; cpu_rw_in = 1'b1;
        @(negedge m2);
        #1;
    endtask

    task automatic bus_cycle(input logic [14:0] a, input logic [7:0] d,
                             input logic rs, input logic rw);
        @(posedge m2);
        romsel = rs; cpu_rw_in = rw; cpu_addr_in = a; cpu_data_in = d;
        @(negedge m2);
        #1;
        romsel = 1'b0; cpu_rw_in = 1'b1;
    endtask

    task automatic reg_wr(input logic [14:0] a, input logic [7:0] d);
        bus_cycle(a, d, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge m2);
        reset_n = 1'b0;
        @(negedge m2);
        @(posedge m2);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic wait_open();
        while (m_edges[0] < 15) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (got[i] !== reset_cfg(i) || cfg_changed[i] !== 1'b0 || cfg_locked[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: got cfg=%h chg=%b lck=%b, expected cfg=%h chg=0 lck=0",
                         i, got[i], cfg_changed[i], cfg_locked[i], reset_cfg(i));
            end
        end
    endtask

    task automatic test_init_ignore();
        while (m_edges[0] < 2) tick();
        reg_wr(15'h5001, 8'hA5);            // edge 3, inside INIT for both
        wait_open();
        reg_wr(15'h5007, 8'h01);
        tick();
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (cpu_base[i] !== 13'h0000 || cfg_changed[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL init_ignore inst%0d: cpu_base=%h chg=%b, expected 0000 chg=1",
                         i, cpu_base[i], cfg_changed[i]);
            end
        end
    endtask

    task automatic test_commit_basic();
        reg_wr(15'h5001, 8'hA5);
        reg_wr(15'h5000, 8'h13);
        reg_wr(15'h5002, 8'h70);
        reg_wr(15'h5007, 8'h01);            // edge N
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (cpu_base[i] !== 13'h0000 || prg_mask[i] !== (i == 0 ? 7'h7E : 7'h3C) ||
                cfg_changed[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL commit_early inst%0d: base=%h pmask=%h chg=%b, expected unchanged",
                         i, cpu_base[i], prg_mask[i], cfg_changed[i]);
            end
        end
        tick();                             // edge N+1
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (cpu_base[i] !== 13'h13A5 || prg_mask[i] !== 7'h70 || cfg_changed[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL commit_load inst%0d: base=%h pmask=%h chg=%b, expected 13a5 70 1",
                         i, cpu_base[i], prg_mask[i], cfg_changed[i]);
            end
        end
        tick();                             // edge N+2
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (cfg_changed[i] !== 1'b0 || cpu_base[i] !== 13'h13A5) begin
                n_fail++;
                $display("FAIL commit_pulse inst%0d: chg=%b base=%h, expected chg=0 base=13a5",
                         i, cfg_changed[i], cpu_base[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        reg_wr(15'h5003, 8'h02);
        reg_wr(15'h5007, 8'h01);
        tick();
        reg_wr(15'h5007, 8'h01);            // edge N
        reg_wr(15'h5003, 8'h1F);            // edge N+1, lands after the snapshot
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (chr_mask[i] !== 5'h02 || cfg_changed[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_first inst%0d: cmask=%h chg=%b, expected 02 chg=1",
                         i, chr_mask[i], cfg_changed[i]);
            end
        end
        reg_wr(15'h5007, 8'h01);
        tick();
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (chr_mask[i] !== 5'h1F) begin
                n_fail++;
                $display("FAIL b2b_second inst%0d: cmask=%h, expected 1f", i, chr_mask[i]);
            end
        end
    endtask

    task automatic test_decode();
        bus_cycle(15'h5A05, 8'h1E, 1'b0, 1'b0);     // romsel low
        bus_cycle(15'h5005, 8'h15, 1'b1, 1'b1);     // read cycle
        bus_cycle(15'h3005, 8'h16, 1'b1, 1'b0);     // outside window
        reg_wr(15'h5007, 8'h01);
        tick();
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (mapper[i] !== 5'h00) begin
                n_fail++;
                $display("FAIL decode_ignore inst%0d: mapper=%h, expected 00", i, mapper[i]);
            end
        end
        reg_wr(15'h5FFD, 8'h07);                    // R5 mirror
        reg_wr(15'h5007, 8'h01);
        tick();
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (mapper[i] !== 5'h07) begin
                n_fail++;
                $display("FAIL decode_mirror inst%0d: mapper=%h, expected 07", i, mapper[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [14:0] a;
        logic [7:0]  d;
        int op;
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            a = 15'($urandom);
            if ($urandom_range(0, 7) != 0) a[14:12] = 3'b101;
            if ($urandom_range(0, 5) == 0) a[2:0] = 3'd7;
            d = 8'($urandom);
            if (a[2:0] == 3'd7) d[7] = 1'b0;
            if (op < 2) tick();
            else if (op == 2) bus_cycle(a, d, 1'b1, 1'b1);
            else bus_cycle(a, d, ($urandom_range(0, 7) != 0), 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_run++;
                if (got[i] !== m_act[i] || cfg_changed[i] !== m_chg[i] || cfg_locked[i] !== m_lck[i]) begin
                    n_fail++;
                    $display("FAIL random[%0d] inst%0d: cfg=%h chg=%b lck=%b, expected cfg=%h chg=%b lck=%b",
                             n, i, got[i], cfg_changed[i], cfg_locked[i], m_act[i], m_chg[i], m_lck[i]);
                end
            end
        end
        tick();
        tick();
    endtask

    task automatic test_lock();
        reg_wr(15'h5005, 8'h04);
        reg_wr(15'h5007, 8'h81);
        tick();
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (mapper[i] !== 5'h04 || cfg_locked[i] !== (i == 0) || cfg_changed[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_set inst%0d: mapper=%h lck=%b chg=%b, expected 04 lck=%0d chg=1",
                         i, mapper[i], cfg_locked[i], cfg_changed[i], (i == 0));
            end
        end
        reg_wr(15'h5005, 8'h09);
        reg_wr(15'h5007, 8'h01);
        tick();
        n_run++;
        if (mapper[0] !== 5'h04 || cfg_changed[0] !== 1'b0 || cfg_locked[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_hold inst0: mapper=%h chg=%b lck=%b, expected 04 chg=0 lck=1",
                     mapper[0], cfg_changed[0], cfg_locked[0]);
        end
        n_run++;
        if (mapper[1] !== 5'h09 || cfg_changed[1] !== 1'b1 || cfg_locked[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL nolock_commit inst1: mapper=%h chg=%b lck=%b, expected 09 chg=1 lck=0",
                     mapper[1], cfg_changed[1], cfg_locked[1]);
        end
    endtask

    task automatic test_reset_mid_commit();
        do_reset();
        wait_open();
        reg_wr(15'h5005, 8'h0A);
        reg_wr(15'h5002, 8'h11);
        reg_wr(15'h5007, 8'h01);            // both instances now in COMMIT
        #1;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (got[i] !== reset_cfg(i) || cfg_changed[i] !== 1'b0 || cfg_locked[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_async inst%0d: cfg=%h chg=%b lck=%b, expected cfg=%h chg=0 lck=0",
                         i, got[i], cfg_changed[i], cfg_locked[i], reset_cfg(i));
            end
        end
        @(posedge m2);
        reset_n = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (got[i] !== reset_cfg(i) || cfg_changed[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_discard inst%0d: cfg=%h chg=%b, expected cfg=%h chg=0",
                         i, got[i], cfg_changed[i], reset_cfg(i));
            end
        end
    endtask

    task automatic test_init_boundary();
        do_reset();
        while (m_edges[0] < 14) tick();
        reg_wr(15'h5005, 8'h11);            // edge 15: last INIT edge for inst0
        reg_wr(15'h5006, 8'h05);            // edge 16: first accepted (inst0)
        reg_wr(15'h5007, 8'h01);
        tick();
        n_run++;
        if (mapper[0] !== 5'h00 || prg_write_enabled[0] !== 1'b1 || map_rom_on_6000[0] !== 1'b1 ||
            chr_write_enabled[0] !== 1'b0 || four_screen[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL init_boundary inst0: mapper=%h pwe=%b cwe=%b rom6=%b fs=%b, expected 00 1 0 1 0",
                     mapper[0], prg_write_enabled[0], chr_write_enabled[0], map_rom_on_6000[0], four_screen[0]);
        end
        n_run++;
        if (mapper[1] !== 5'h11 || prg_write_enabled[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL init_boundary inst1: mapper=%h pwe=%b, expected 11 1", mapper[1], prg_write_enabled[1]);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_run = 0;
        n_fail = 0;
        reset_n = 1'b1;
        romsel = 1'b0;
        cpu_rw_in = 1'b1;
        cpu_addr_in = '0;
        cpu_data_in = '0;
        test_reset();
        test_init_ignore();
        test_commit_basic();
        test_back_to_back();
        test_decode();
        test_random();
        test_lock();
        test_reset_mid_commit();
        test_init_boundary();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
